// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned ALU_W      = 16;
  localparam int unsigned LAT_W      = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_t;

  typedef struct packed {
    op_t              op;
    logic [ALU_W-1:0] addr;
  } req_t;

  // An address is backed by RAM only when every bit above the implemented width is zero.
  function automatic logic addr_in_range(input logic [ALU_W-1:0] addr, input int unsigned aw);
    return (addr >> aw) == '0;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, asynchronous read, contents survive reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: captures one request, waits LATENCY cycles, then
// performs the RAM access and pulses memReady (plus memErr on bad addresses).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ALU_W-1:0]  aluOut,
  input  logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] memData,
  output logic              memReady,
  output logic              busy,
  output logic              memErr
);
  localparam logic [LAT_W-1:0] LAT_LOAD = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

  state_t            state;
  logic [LAT_W-1:0]  cnt;
  req_t              req_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata;
  logic              in_range;
  logic              ram_we;

  assign in_range = addr_in_range(req_q.addr, ADDR_W);
  // Write lands at the end of RESP; out-of-range stores are dropped.
  assign ram_we   = (state == RESP) && (req_q.op == OP_WR) && in_range;

  dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (req_q.addr[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // Outputs lag the state by one edge, so memReady shows LATENCY+1 cycles after accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= '0;
      wdata_q  <= '0;
      memData  <= '0;
      memReady <= 1'b0;
      busy     <= 1'b0;
      memErr   <= 1'b0;
    end else begin
      memReady <= 1'b0;
      memErr   <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (memRead ^ memWrite) begin
            req_q.addr <= aluOut;
            req_q.op   <= memWrite ? OP_WR : OP_RD;
            wdata_q    <= readData2;
            busy       <= 1'b1;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              cnt   <= LAT_LOAD;
              state <= WAIT;
            end
          end else if (memRead && memWrite) begin
            memErr <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 1'b1;
        end
        RESP: begin
          memReady <= 1'b1;
          busy     <= 1'b1;
          memErr   <= !in_range;
          if (req_q.op == OP_RD) memData <= in_range ? rdata : '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=0,
// checked against a word-array memory model.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd  [2];
  logic        wr  [2];
  logic [15:0] addr[2];
  logic [15:0] wd  [2];
  logic [15:0] md  [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        err [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] model   [2][2048];
  bit          written [2][2048];
  logic [15:0] last_md [2];

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(16), .ADDR_W(11), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(rst_n), .memRead(rd[0]), .memWrite(wr[0]), .aluOut(addr[0]),
    .readData2(wd[0]), .memData(md[0]), .memReady(rdy[0]), .busy(bsy[0]), .memErr(err[0]));

  data_mem_responder #(.DATA_W(16), .ADDR_W(11), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .memRead(rd[1]), .memWrite(wr[1]), .aluOut(addr[1]),
    .readData2(wd[1]), .memData(md[1]), .memReady(rdy[1]), .busy(bsy[1]), .memErr(err[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit in_range(input logic [15:0] a);
    return a < 16'h0800;
  endfunction

  // Drives one request, optionally scrambling inputs while waiting; drops it on memReady.
  task automatic txn(input int d, input bit is_wr, input logic [15:0] a, input logic [15:0] data,
                     input bit scramble, output int cycles, output logic [15:0] got_md,
                     output logic got_err, output logic busy_ok);
    rd[d] = !is_wr; wr[d] = is_wr; addr[d] = a; wd[d] = data;
    @(posedge clk); #1;
    busy_ok = bsy[d];
    cycles = -1; got_md = 'x; got_err = 1'bx;
    for (int n = 1; n <= 40 && cycles < 0; n++) begin
      if (scramble) begin
        rd[d] = 1'($urandom); wr[d] = 1'($urandom);
        addr[d] = 16'($urandom); wd[d] = 16'($urandom);
      end
      @(posedge clk); #1;
      if (rdy[d]) begin
        cycles = n; got_md = md[d]; got_err = err[d];
      end else if (!bsy[d]) begin
        busy_ok = 1'b0;
      end
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (md[d] !== 16'h0000) begin n_fail++; $display("FAIL reset_md d%0d: got %h want 0000", d, md[d]); end
      n_tests++; if ({rdy[d], bsy[d], err[d]} !== 3'b000) begin n_fail++; $display("FAIL reset_flags d%0d: got %b want 000", d, {rdy[d], bsy[d], err[d]}); end
      last_md[d] = 16'h0000;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int cyc; logic [15:0] gmd; logic gerr; logic bok;
    txn(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, cyc, gmd, gerr, bok);
    model[0][16'h0010] = 16'hBEEF; written[0][16'h0010] = 1'b1;
    n_tests++; if (bok !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", bok); end
    n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL wr_latency: got %0d want 3", cyc); end
    n_tests++; if (gerr !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", gerr); end
    @(posedge clk); #1;
    n_tests++; if ({rdy[0], bsy[0]} !== 2'b00) begin n_fail++; $display("FAIL wr_release: got %b want 00", {rdy[0], bsy[0]}); end
    txn(0, 1'b0, 16'h0010, 16'h0000, 1'b0, cyc, gmd, gerr, bok);
    n_tests++; if (cyc != 3) begin n_fail++; $display("FAIL rd_latency: got %0d want 3", cyc); end
    n_tests++; if (gmd !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h want beef", gmd); end
    txn(0, 1'b1, 16'h0020, 16'h1234, 1'b0, cyc, gmd, gerr, bok);
    model[0][16'h0020] = 16'h1234; written[0][16'h0020] = 1'b1;
    n_tests++; if (gmd !== 16'hBEEF) begin n_fail++; $display("FAIL md_hold_on_write: got %h want beef", gmd); end
    last_md[0] = 16'hBEEF;
  endtask

  task automatic test_back_to_back();
    int cyc; logic [15:0] gmd; logic gerr; logic bok;
    txn(1, 1'b1, 16'h0001, 16'h00AA, 1'b0, cyc, gmd, gerr, bok);
    model[1][16'h0001] = 16'h00AA; written[1][16'h0001] = 1'b1;
    n_tests++; if (cyc != 1) begin n_fail++; $display("FAIL b2b_wr_latency: got %0d want 1", cyc); end
    txn(1, 1'b0, 16'h0001, 16'h0000, 1'b0, cyc, gmd, gerr, bok);
    n_tests++; if (cyc != 1) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d want 1", cyc); end
    n_tests++; if (gmd !== 16'h00AA) begin n_fail++; $display("FAIL b2b_rd_data: got %h want 00aa", gmd); end
    n_tests++; if (bok !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", bok); end
    last_md[1] = 16'h00AA;
  endtask

  task automatic test_illegal();
    int cyc; logic [15:0] gmd; logic gerr; logic bok;
    rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0010;
    @(posedge clk); #1;
    n_tests++; if ({err[0], rdy[0], bsy[0]} !== 3'b100) begin n_fail++; $display("FAIL both_req: got err/rdy/busy %b want 100", {err[0], rdy[0], bsy[0]}); end
    rd[0] = 1'b0; wr[0] = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL both_req_pulse: got %b want 0", err[0]); end
    txn(0, 1'b1, 16'h0000, 16'h7E57, 1'b0, cyc, gmd, gerr, bok);
    model[0][0] = 16'h7E57; written[0][0] = 1'b1;
    txn(0, 1'b0, 16'h0800, 16'h0000, 1'b0, cyc, gmd, gerr, bok);
    n_tests++; if (cyc != 3 || gerr !== 1'b1 || gmd !== 16'h0000) begin
      n_fail++; $display("FAIL range_rd: got cyc=%0d err=%b md=%h want 3 1 0000", cyc, gerr, gmd); end
    txn(0, 1'b1, 16'hF000, 16'hDEAD, 1'b0, cyc, gmd, gerr, bok);
    n_tests++; if (cyc != 3 || gerr !== 1'b1 || gmd !== 16'h0000) begin
      n_fail++; $display("FAIL range_wr: got cyc=%0d err=%b md=%h want 3 1 0000", cyc, gerr, gmd); end
    foreach (written[0][i]) if (written[0][i]) begin
      txn(0, 1'b0, 16'(i), 16'h0000, 1'b0, cyc, gmd, gerr, bok);
      n_tests++; if (gmd !== model[0][i] || gerr !== 1'b0) begin
        n_fail++; $display("FAIL readback %h: got %h err=%b want %h err=0", 16'(i), gmd, gerr, model[0][i]); end
      last_md[0] = model[0][i];
    end
  endtask

  task automatic test_reset_mid_wait();
    int cyc; logic [15:0] gmd; logic gerr; logic bok;
    txn(0, 1'b1, 16'h0005, 16'h0A0A, 1'b0, cyc, gmd, gerr, bok);
    model[0][5] = 16'h0A0A; written[0][5] = 1'b1;
    txn(0, 1'b0, 16'h0005, 16'h0000, 1'b0, cyc, gmd, gerr, bok);
    n_tests++; if (gmd !== 16'h0A0A) begin n_fail++; $display("FAIL pre_reset_rd: got %h want 0a0a", gmd); end
    wr[0] = 1'b1; addr[0] = 16'h0005; wd[0] = 16'h5555;
    @(posedge clk); #1;
    n_tests++; if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_wait_busy: got %b want 1", bsy[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({md[0], rdy[0], bsy[0], err[0]} !== 19'h0) begin
      n_fail++; $display("FAIL async_reset: got md=%h rdy=%b busy=%b err=%b want all 0", md[0], rdy[0], bsy[0], err[0]); end
    wr[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_md[0] = 16'h0000; last_md[1] = 16'h0000;
    @(posedge clk); #1;
    txn(0, 1'b0, 16'h0005, 16'h0000, 1'b0, cyc, gmd, gerr, bok);
    n_tests++; if (gmd !== 16'h0A0A) begin n_fail++; $display("FAIL aborted_write: got %h want 0a0a", gmd); end
    last_md[0] = 16'h0A0A;
  endtask

  // Random reads/writes; reads target only addresses the model knows, or out-of-range ones.
  task automatic test_random(input int d, input int count, input bit scramble);
    int cyc; logic [15:0] gmd; logic gerr; logic bok;
    logic [15:0] a, data, exp_md; bit is_wr; logic exp_err;
    for (int k = 0; k < count; k++) begin
      is_wr = 1'($urandom);
      if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(16'h0800, 16'hFFFF));
      else                           a = 16'($urandom_range(0, 63));
      data = 16'($urandom);
      if (!is_wr && in_range(a) && !written[d][a[10:0]]) is_wr = 1'b1;
      txn(d, is_wr, a, data, scramble, cyc, gmd, gerr, bok);
      exp_err = !in_range(a);
      if (is_wr) begin
        exp_md = last_md[d];
        if (in_range(a)) begin model[d][a[10:0]] = data; written[d][a[10:0]] = 1'b1; end
      end else begin
        exp_md = in_range(a) ? model[d][a[10:0]] : 16'h0000;
      end
      last_md[d] = exp_md;
      n_tests++; if (cyc != lat_of(d) + 1 || gerr !== exp_err || gmd !== exp_md || bok !== 1'b1) begin
        n_fail++;
        $display("FAIL rand d%0d #%0d %s %h: got cyc=%0d err=%b md=%h busy=%b want cyc=%0d err=%b md=%h busy=1",
                 d, k, is_wr ? "wr" : "rd", a, cyc, gerr, gmd, bok, lat_of(d) + 1, exp_err, exp_md);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 16'h0000; wd[d] = 16'h0000; last_md[d] = 16'h0000;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_illegal();
    test_reset_mid_wait();
    test_random(0, 200, 1'b1);
    test_random(1, 60, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder at the far end of the processor's load/store interface.
- Accepts one memRead or memWrite request at a time, with a word address on aluOut and store data on readData2.
- Serves the request from an internal 16-bit word RAM after a programmable number of wait cycles.
- Returns memData and a one-cycle memReady pulse; holds busy high so the core can stall.

Parameters:
- DATA_W, 16, data word width; matches register and ALU width.
- ADDR_W, 11, implemented word-address bits; depth = 2**ADDR_W words.
- LATENCY, 2, wait cycles between request accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- memRead  input  1  load request; level, sampled only in IDLE.
- memWrite  input  1  store request; level, sampled only in IDLE.
- aluOut  input  16  word address of the request.
- readData2  input  DATA_W  store data.
- memData  output  DATA_W  load data; valid when memReady=1, held until the next load completes.
- memReady  output  1  one-cycle pulse: the request has completed.
- busy  output  1  high from the accept cycle through the RESP cycle; the core must stall and hold its request.
- memErr  output  1  one-cycle pulse: illegal request.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, memData=0, memReady=0, busy=0, memErr=0, captured request registers=0.
- Reset does not clear RAM contents. A reset mid-operation aborts the request; a pending write is not performed.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If exactly one of memRead/memWrite is 1: capture aluOut, readData2 and the op; set busy=1.
    - LATENCY=0: go to RESP.
    - Otherwise: load counter=LATENCY-1 and go to WAIT.
  - If both are 1: pulse memErr next cycle, stay IDLE, no access.
  - If neither is 1: stay IDLE.
- WAIT: decrement the counter each cycle; at counter=0 go to RESP. Inputs are ignored.
- RESP (one cycle), then IDLE; busy deasserts on exit.
  - memReady=1, busy=1.
  - Write op: RAM[addr] <= captured data at the end of this cycle.
  - Read op: memData presents RAM[addr].
- Accept cycle counts as cycle 0. memReady rises LATENCY+1 cycles after the accept edge.
- A request still held in the IDLE cycle after RESP is accepted as a new transaction. The core must drop its request once memReady is seen.
- Range check: if captured addr[15:ADDR_W] != 0, RESP still occurs with memReady=1 and memErr=1.
  - Read returns 0.
  - Write is dropped; RAM is unchanged.
- Read-after-write to the same address in consecutive transactions returns the new data.
- memData is updated only on a read RESP; writes and errors leave it unchanged (except the range-error read, which loads 0).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}.
  - DATA_W / ADDR_W defaults.
  - LAT_W=4 counter width.
  - op encoding: OP_RD=0, OP_WR=1.
- Sub-module dmem_array: single-port word RAM, DATA_W x 2**ADDR_W.
  - Synchronous write enable.
  - Read data available for the RESP cycle.
  - No reset.
- The FSM, counter, range check and output registers live in the top module.

Test Plan:
- Reset, then write: reset low 3 cycles, release; LATENCY=2; memWrite=1, aluOut=0x0010, readData2=0xBEEF -> busy=1 from the accept edge, memReady pulses exactly 3 cycles after accept, memErr=0.
- Read-back: memRead=1, aluOut=0x0010 after the previous memReady -> memData=0xBEEF with a memReady pulse. memData stays 0xBEEF through a later write to 0x0020 (0x1234).
- LATENCY=0 back-to-back: write 0x0001 <- 0x00AA, then immediately read 0x0001 -> each memReady one cycle after accept, read returns 0x00AA, one idle cycle between transactions.
- Illegal requests:
  - memRead=memWrite=1 -> memErr pulse, no memReady, busy stays 0.
  - Read at aluOut=0x0800 (ADDR_W=11) -> memReady=1, memErr=1, memData=0x0000.
  - Write at 0xF000 -> RAM unchanged, verified by reading all previously written addresses.
- Reset mid-WAIT: write 0x0005 <- 0x5555 accepted, reset asserted in WAIT -> all outputs 0 immediately (asynchronous). A later read of 0x0005 returns its prior value, not 0x5555.
- Ignored inputs: toggle memRead/aluOut during WAIT -> no effect on the captured transaction; a random sequence of 200 reads/writes matches a reference memory model.
